// File: rtl/keyexpansion_multi.sv
// AES key-schedule engine for 128/192/256-bit keys, selected per run.
// One schedule word per clock; the whole schedule is kept in a word store
// and served as 128-bit round keys through a registered read port.

// AES S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = p;
        for (int k = 0; k < 8; k++) begin
            if (q[k]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] w_x2;
    logic [7:0] w_x3;
    logic [7:0] w_x6;
    logic [7:0] w_x12;
    logic [7:0] w_x15;
    logic [7:0] w_x30;
    logic [7:0] w_x60;
    logic [7:0] w_x120;
    logic [7:0] w_x240;
    logic [7:0] w_inv;

    // Addition chain to x^254, which is the multiplicative inverse (0 maps to 0)
    always_comb begin
        w_x2   = gf_mul(a, a);
        w_x3   = gf_mul(w_x2, a);
        w_x6   = gf_mul(w_x3, w_x3);
        w_x12  = gf_mul(w_x6, w_x6);
        w_x15  = gf_mul(w_x12, w_x3);
        w_x30  = gf_mul(w_x15, w_x15);
        w_x60  = gf_mul(w_x30, w_x30);
        w_x120 = gf_mul(w_x60, w_x60);
        w_x240 = gf_mul(w_x120, w_x120);
        w_inv  = gf_mul(gf_mul(w_x240, w_x12), w_x2);
    end

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    assign y = w_inv
             ^ {w_inv[6:0], w_inv[7]}
             ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]}
             ^ {w_inv[3:0], w_inv[7:4]}
             ^ 8'h63;

endmodule

module keyexpansion_multi #(
    parameter int MAX_NK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*MAX_NK-1:0]  key,
    output logic                  busy,
    output logic                  done,
    output logic                  ready,
    output logic                  err,
    input  logic [3:0]            rk_idx,
    output logic [127:0]          rk
);

    localparam int KW    = 32 * MAX_NK;
    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_GEN
    } state_t;

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic           r_ready;
    logic           r_err;
    logic [7:0]     r_rcon;
    logic [3:0]     r_nk;
    logic [AW-1:0]  r_idx;
    logic [2:0]     r_mod;
    logic [127:0]   r_rk;

    // Full schedule store, and a sliding window of the last MAX_NK words.
    // The window is top-aligned: r_win[MAX_NK-1] is w[i-1] and
    // r_win[MAX_NK-Nk] is w[i-Nk].
    logic [31:0]    r_mem [DEPTH];
    logic [31:0]    r_win [MAX_NK];

    logic [3:0]     w_nk_in;
    logic           w_len_ok;
    logic [3:0]     w_off;
    logic [KW-1:0]  w_key_shift;
    logic [31:0]    w_key_word [MAX_NK];
    logic [31:0]    w_win_load [MAX_NK];
    logic           w_accept;

    logic [31:0]    w_prev;
    logic [31:0]    w_old;
    logic           w_rot_step;
    logic           w_sub_step;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [31:0]    w_temp;
    logic [31:0]    w_new;
    logic [7:0]     w_rcon_next;
    logic           w_mod_wrap;
    logic [AW-1:0]  w_last_idx;
    logic           w_last;
    logic [AW-1:0]  w_rd_base;
    logic           w_rd_ok;

    // Decode key_len into Nk and reject codes this instance cannot hold
    always_comb begin
        w_nk_in  = 4'd4;
        w_len_ok = 1'b1;
        case (key_len)
            2'b00:   w_nk_in = 4'd4;
            2'b01:   w_nk_in = 4'd6;
            2'b10:   w_nk_in = 4'd8;
            default: begin
                w_nk_in  = 4'd4;
                w_len_ok = 1'b0;
            end
        endcase
        if (int'(w_nk_in) > MAX_NK) begin
            w_len_ok = 1'b0;
        end
    end

    assign w_accept = (r_state == S_IDLE) && start && !r_done && w_len_ok;

    // Shift the key so its Nk used words land at the top of the window
    assign w_off       = 4'(MAX_NK) - w_nk_in;
    assign w_key_shift = key >> {w_off, 5'b00000};

    genvar gi;
    generate
        for (gi = 0; gi < MAX_NK; gi++) begin : g_key
            assign w_key_word[gi] = key[KW-1-32*gi -: 32];
            assign w_win_load[gi] = w_key_shift[32*(MAX_NK-1-gi) +: 32];
        end
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            sbox u_sbox (
                .a (w_sub_in[8*gi +: 8]),
                .y (w_sub_out[8*gi +: 8])
            );
        end
    endgenerate

    // Pick w[i-1] and w[i-Nk] out of the window, classify the step
    always_comb begin
        w_prev = r_win[MAX_NK-1];
        w_old  = r_win[0];
        for (int j = 0; j < MAX_NK; j++) begin
            if (j == MAX_NK - int'(r_nk)) begin
                w_old = r_win[j];
            end
        end
        w_rot_step = (r_mod == 3'd0);
        w_sub_step = (r_nk == 4'd8) && (r_mod == 3'd4);
    end

    assign w_sub_in = w_rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    // Form temp and the new schedule word
    always_comb begin
        w_temp = w_prev;
        if (w_rot_step) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h000000};
        end else if (w_sub_step) begin
            w_temp = w_sub_out;
        end
        w_new = w_old ^ w_temp;
    end

    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);
    assign w_mod_wrap  = (({1'b0, r_mod} + 4'd1) == r_nk);
    assign w_last_idx  = AW'({r_nk, 2'b00}) + AW'(27);
    assign w_last      = (r_idx == w_last_idx);

    // Control FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rcon  <= 8'h01;
            r_nk    <= 4'd4;
            r_idx   <= '0;
            r_mod   <= 3'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is dropped
                    if (start && !r_done) begin
                        if (!w_len_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_nk    <= w_nk_in;
                            r_idx   <= AW'(w_nk_in);
                            r_mod   <= 3'd0;
                            r_rcon  <= 8'h01;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_GEN;
                        end
                    end
                end
                S_GEN: begin
                    r_idx <= r_idx + AW'(1);
                    r_mod <= w_mod_wrap ? 3'd0 : r_mod + 3'd1;
                    if (w_rot_step) begin
                        r_rcon <= w_rcon_next;
                    end
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Schedule storage and window: load the key on accept, append during GEN
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            for (int k = 0; k < MAX_NK; k++) begin
                r_win[k] <= w_win_load[k];
                if (k < int'(w_nk_in)) begin
                    r_mem[AW'(k)] <= w_key_word[k];
                end
            end
        end else if (r_state == S_GEN) begin
            for (int k = 0; k < MAX_NK - 1; k++) begin
                r_win[k] <= r_win[k+1];
            end
            r_win[MAX_NK-1] <= w_new;
            r_mem[r_idx]    <= w_new;
        end
    end

    assign w_rd_base = AW'({rk_idx, 2'b00});
    assign w_rd_ok   = r_ready && ({1'b0, rk_idx} <= ({1'b0, r_nk} + 5'd6));

    // Registered round-key read; zero when not ready or index beyond Nr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rk <= '0;
        end else if (w_rd_ok) begin
            r_rk <= {r_mem[w_rd_base],
                     r_mem[w_rd_base + AW'(1)],
                     r_mem[w_rd_base + AW'(2)],
                     r_mem[w_rd_base + AW'(3)]};
        end else begin
            r_rk <= '0;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign ready = r_ready;
    assign err   = r_err;
    assign rk    = r_rk;

endmodule

// File: tb/tb_keyexpansion_multi.sv
// Self-checking bench for keyexpansion_multi: known-answer vectors plus
// randomized keys checked against a table-driven AES key-schedule model.
module tb_keyexpansion_multi;

    logic clk;
    logic rst;

    logic         start8;
    logic [1:0]   key_len8;
    logic [255:0] key8;
    logic         busy8, done8, ready8, err8;
    logic [3:0]   rk_idx8;
    logic [127:0] rk8;

    logic         start4;
    logic [1:0]   key_len4;
    logic [127:0] key4;
    logic         busy4, done4, ready4, err4;
    logic [3:0]   rk_idx4;
    logic [127:0] rk4;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  sb [256];
    logic [31:0] mw [60];

    keyexpansion_multi #(.MAX_NK(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (start8),
        .key_len (key_len8),
        .key     (key8),
        .busy    (busy8),
        .done    (done8),
        .ready   (ready8),
        .err     (err8),
        .rk_idx  (rk_idx8),
        .rk      (rk8)
    );

    keyexpansion_multi #(.MAX_NK(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .key_len (key_len4),
        .key     (key4),
        .busy    (busy4),
        .done    (done4),
        .ready   (ready4),
        .err     (err4),
        .rk_idx  (rk_idx4),
        .rk      (rk4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // S-box by brute-force inverse search and bitwise affine equation
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int b = 0; b < 8; b++) begin
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            end
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic expand(input int nk, input logic [255:0] k);
        logic [7:0]  rc_tab [10];
        logic [31:0] t;
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        for (int i = 0; i < 60; i++) mw[i] = 32'h0;
        for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = mw[i-1];
            if (i % nk == 0)
                t = sub_word({t[23:0], t[31:24]}) ^ {rc_tab[i/nk-1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = sub_word(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int idx, input int nk);
        if (idx > nk + 6) return 128'h0;
        return {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_run8(input logic [1:0] len, input logic [255:0] k, output int lat);
        @(negedge clk);
        key_len8 = len;
        key8     = k;
        start8   = 1'b1;
        lat      = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8 === 1'b1) begin
                lat = c;
                break;
            end
        end
        $display("run dut8 key_len=%0d latency=%0d", len, lat);
    endtask

    task automatic do_run4(input logic [1:0] len, input logic [127:0] k, output int lat);
        @(negedge clk);
        key_len4 = len;
        key4     = k;
        start4   = 1'b1;
        lat      = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (done4 === 1'b1) begin
                lat = c;
                break;
            end
        end
        $display("run dut4 key_len=%0d latency=%0d", len, lat);
    endtask

    task automatic read8(input int idx, output logic [127:0] v);
        @(negedge clk);
        rk_idx8 = 4'(idx);
        @(negedge clk);
        v = rk8;
        $display("read dut8 idx=%0d rk=%h", idx, v);
    endtask

    task automatic read4(input int idx, output logic [127:0] v);
        @(negedge clk);
        rk_idx4 = 4'(idx);
        @(negedge clk);
        v = rk4;
        $display("read dut4 idx=%0d rk=%h", idx, v);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy8, done8, ready8, err8} !== 4'b0000 || rk8 !== 128'h0) begin
            n_errors++;
            $display("FAIL reset_dut8: got busy=%b done=%b ready=%b err=%b rk=%h, expected all zero",
                     busy8, done8, ready8, err8, rk8);
        end
        n_checks++;
        if ({busy4, done4, ready4, err4} !== 4'b0000 || rk4 !== 128'h0) begin
            n_errors++;
            $display("FAIL reset_dut4: got busy=%b done=%b ready=%b err=%b rk=%h, expected all zero",
                     busy4, done4, ready4, err4, rk4);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aes128_kat();
        logic [255:0] k;
        logic [127:0] v;
        logic [127:0] exp_v;
        int lat;
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        expand(4, k);
        do_run8(2'b00, k, lat);
        n_checks++;
        if (lat !== 41) begin
            n_errors++;
            $display("FAIL aes128_latency: got %0d expected 41", lat);
        end
        n_checks++;
        if (busy8 !== 1'b0 || ready8 !== 1'b1) begin
            n_errors++;
            $display("FAIL aes128_status_at_done: got busy=%b ready=%b expected busy=0 ready=1", busy8, ready8);
        end
        @(negedge clk);
        n_checks++;
        if (done8 !== 1'b0) begin
            n_errors++;
            $display("FAIL aes128_done_pulse: got done=%b one cycle later, expected 0", done8);
        end
        read8(0, v);
        exp_v = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        n_checks++;
        if (v !== exp_v) begin
            n_errors++;
            $display("FAIL aes128_rk0: got %h expected %h", v, exp_v);
        end
        read8(1, v);
        exp_v = 128'ha0fafe1788542cb123a339392a6c7605;
        n_checks++;
        if (v !== exp_v) begin
            n_errors++;
            $display("FAIL aes128_rk1: got %h expected %h", v, exp_v);
        end
        read8(10, v);
        exp_v = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        n_checks++;
        if (v !== exp_v) begin
            n_errors++;
            $display("FAIL aes128_rk10: got %h expected %h", v, exp_v);
        end
        read8(11, v);
        n_checks++;
        if (v !== 128'h0) begin
            n_errors++;
            $display("FAIL aes128_rk11: got %h expected 0", v);
        end
    endtask

    task automatic test_aes192_kat();
        logic [255:0] k;
        logic [127:0] v;
        logic [127:0] exp_v;
        int lat;
        k = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        do_run8(2'b01, k, lat);
        n_checks++;
        if (lat !== 47) begin
            n_errors++;
            $display("FAIL aes192_latency: got %0d expected 47", lat);
        end
        read8(12, v);
        exp_v = 128'he98ba06f448c773c8ecc720401002202;
        n_checks++;
        if (v !== exp_v) begin
            n_errors++;
            $display("FAIL aes192_rk12: got %h expected %h", v, exp_v);
        end
        read8(13, v);
        n_checks++;
        if (v !== 128'h0) begin
            n_errors++;
            $display("FAIL aes192_rk13: got %h expected 0", v);
        end
    endtask

    task automatic test_aes256_kat();
        logic [255:0] k;
        logic [127:0] v;
        logic [127:0] exp_v;
        int lat;
        k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        do_run8(2'b10, k, lat);
        n_checks++;
        if (lat !== 53) begin
            n_errors++;
            $display("FAIL aes256_latency: got %0d expected 53", lat);
        end
        read8(2, v);
        exp_v = 128'h9ba354118e6925afa51a8b5f2067fcde;
        n_checks++;
        if (v !== exp_v) begin
            n_errors++;
            $display("FAIL aes256_rk2: got %h expected %h", v, exp_v);
        end
        read8(14, v);
        exp_v = 128'hfe4890d1e6188d0b046df344706c631e;
        n_checks++;
        if (v !== exp_v) begin
            n_errors++;
            $display("FAIL aes256_rk14: got %h expected %h", v, exp_v);
        end
        read8(15, v);
        n_checks++;
        if (v !== 128'h0) begin
            n_errors++;
            $display("FAIL aes256_rk15: got %h expected 0", v);
        end
    endtask

    task automatic test_random_keys();
        logic [255:0] k;
        logic [127:0] v;
        logic [1:0]   len;
        int nk;
        int lat;
        int exp_lat;
        for (int rep = 0; rep < 6; rep++) begin
            len = 2'(rep % 3);
            nk  = 4 + 2 * (rep % 3);
            exp_lat = (nk == 4) ? 41 : ((nk == 6) ? 47 : 53);
            k = rand_key();
            expand(nk, k);
            do_run8(len, k, lat);
            n_checks++;
            if (lat !== exp_lat) begin
                n_errors++;
                $display("FAIL random_latency rep=%0d: got %0d expected %0d", rep, lat, exp_lat);
            end
            for (int idx = 0; idx < 16; idx++) begin
                read8(idx, v);
                n_checks++;
                if (v !== model_rk(idx, nk)) begin
                    n_errors++;
                    $display("FAIL random_rk rep=%0d idx=%0d: got %h expected %h",
                             rep, idx, v, model_rk(idx, nk));
                end
            end
        end
    endtask

    task automatic test_busy_and_restart();
        logic [255:0] ka;
        logic [255:0] kb;
        logic [127:0] v;
        int lat;
        ka = rand_key();
        kb = rand_key();
        expand(4, ka);
        @(negedge clk);
        key_len8 = 2'b00;
        key8     = ka;
        start8   = 1'b1;
        rk_idx8  = 4'd1;
        lat      = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (c == 20) begin
                start8   = 1'b1;
                key_len8 = 2'b10;
                key8     = kb;
            end
            if (c >= 2 && c <= 40) begin
                n_checks++;
                if (busy8 !== 1'b1 || rk8 !== 128'h0) begin
                    n_errors++;
                    $display("FAIL gen_status cycle=%0d: got busy=%b rk=%h expected busy=1 rk=0", c, busy8, rk8);
                end
            end
            if (done8 === 1'b1) begin
                lat = c;
                break;
            end
        end
        $display("run dut8 restart-during-busy latency=%0d", lat);
        n_checks++;
        if (lat !== 41) begin
            n_errors++;
            $display("FAIL restart_latency: got %0d expected 41", lat);
        end
        for (int idx = 0; idx < 12; idx++) begin
            read8(idx, v);
            n_checks++;
            if (v !== model_rk(idx, 4)) begin
                n_errors++;
                $display("FAIL restart_rk idx=%0d: got %h expected %h", idx, v, model_rk(idx, 4));
            end
        end
    endtask

    task automatic test_start_on_done();
        logic [255:0] kc;
        logic [255:0] kd;
        logic [127:0] v;
        int lat;
        kc = rand_key();
        kd = rand_key();
        do_run8(2'b01, kc, lat);
        n_checks++;
        if (lat !== 47) begin
            n_errors++;
            $display("FAIL start_on_done_first_latency: got %0d expected 47", lat);
        end
        // start raised in the done cycle, held one more cycle
        key_len8 = 2'b00;
        key8     = kd;
        start8   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b0) begin
            n_errors++;
            $display("FAIL start_on_done_ignored: got busy=%b expected 0", busy8);
        end
        @(negedge clk);
        start8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_errors++;
            $display("FAIL start_after_done_accepted: got busy=%b expected 1", busy8);
        end
        lat = -1;
        for (int c = 2; c <= 200; c++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                lat = c;
                break;
            end
        end
        $display("run dut8 start-after-done latency=%0d", lat);
        n_checks++;
        if (lat !== 41) begin
            n_errors++;
            $display("FAIL start_after_done_latency: got %0d expected 41", lat);
        end
        expand(4, kd);
        for (int idx = 0; idx < 11; idx += 5) begin
            read8(idx, v);
            n_checks++;
            if (v !== model_rk(idx, 4)) begin
                n_errors++;
                $display("FAIL start_after_done_rk idx=%0d: got %h expected %h", idx, v, model_rk(idx, 4));
            end
        end
    endtask

    task automatic test_illegal();
        logic [127:0] v;
        logic [255:0] k;
        int lat;
        // dut8 currently holds the schedule expanded into mw
        @(negedge clk);
        key_len8 = 2'b11;
        key8     = rand_key();
        start8   = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n_checks++;
        if (err8 !== 1'b1 || busy8 !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal8_err: got err=%b busy=%b expected err=1 busy=0", err8, busy8);
        end
        @(negedge clk);
        n_checks++;
        if (err8 !== 1'b0 || busy8 !== 1'b0 || ready8 !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal8_after: got err=%b busy=%b ready=%b expected 0 0 1", err8, busy8, ready8);
        end
        read8(1, v);
        n_checks++;
        if (v !== model_rk(1, 4)) begin
            n_errors++;
            $display("FAIL illegal8_keys_kept: got %h expected %h", v, model_rk(1, 4));
        end
        // MAX_NK=4 instance: load a valid key, then request 256 and 192
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        expand(4, k);
        do_run4(2'b00, k[255:128], lat);
        n_checks++;
        if (lat !== 41) begin
            n_errors++;
            $display("FAIL dut4_latency: got %0d expected 41", lat);
        end
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            key_len4 = (t == 0) ? 2'b10 : 2'b01;
            key4     = k[255:128] ^ 128'h1;
            start4   = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            n_checks++;
            if (err4 !== 1'b1 || busy4 !== 1'b0) begin
                n_errors++;
                $display("FAIL illegal4_err t=%0d: got err=%b busy=%b expected err=1 busy=0", t, err4, busy4);
            end
            @(negedge clk);
            n_checks++;
            if (err4 !== 1'b0 || busy4 !== 1'b0 || ready4 !== 1'b1) begin
                n_errors++;
                $display("FAIL illegal4_after t=%0d: got err=%b busy=%b ready=%b expected 0 0 1",
                         t, err4, busy4, ready4);
            end
            read4(1, v);
            n_checks++;
            if (v !== model_rk(1, 4)) begin
                n_errors++;
                $display("FAIL illegal4_keys_kept t=%0d: got %h expected %h", t, v, model_rk(1, 4));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] k;
        logic [127:0] v;
        int lat;
        rk_idx8 = 4'd0;
        @(negedge clk);
        key_len8 = 2'b10;
        key8     = rand_key();
        start8   = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy8 !== 1'b0 || ready8 !== 1'b0 || rk8 !== 128'h0 || done8 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: got busy=%b ready=%b done=%b rk=%h expected all zero",
                     busy8, ready8, done8, rk8);
        end
        @(negedge clk);
        n_checks++;
        if (busy8 !== 1'b0 || rk8 !== 128'h0) begin
            n_errors++;
            $display("FAIL reset_mid_stays_idle: got busy=%b rk=%h expected 0 0", busy8, rk8);
        end
        k = rand_key();
        expand(4, k);
        do_run8(2'b00, k, lat);
        n_checks++;
        if (lat !== 41) begin
            n_errors++;
            $display("FAIL reset_mid_rerun_latency: got %0d expected 41", lat);
        end
        for (int idx = 0; idx < 12; idx++) begin
            read8(idx, v);
            n_checks++;
            if (v !== model_rk(idx, 4)) begin
                n_errors++;
                $display("FAIL reset_mid_rerun_rk idx=%0d: got %h expected %h", idx, v, model_rk(idx, 4));
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start8   = 1'b0;
        key_len8 = 2'b00;
        key8     = '0;
        rk_idx8  = 4'd0;
        start4   = 1'b0;
        key_len4 = 2'b00;
        key4     = '0;
        rk_idx4  = 4'd0;
        build_sbox();
        test_reset();
        test_aes128_kat();
        test_aes192_kat();
        test_aes256_kat();
        test_random_keys();
        test_busy_and_restart();
        test_start_on_done();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
